// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-back controller and hazard scoreboard for the 32x32 integer register file.
// The single register-file write port is shared between the ALU and LSU result
// streams with a round-robin arbiter. A busy bit per register tracks in-flight
// destinations so that issue stalls on RAW and WAW hazards.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   issue_valid_i/_rd_i/_rd_we_i/_rs1_i/_rs2_i   decoder issue request
//   issue_ready_o                no hazard on rs1/rs2/rd (combinational from busy)
//   alu_valid_i/_rd_i/_data_i    ALU result stream, alu_ready_o = grant
//   lsu_valid_i/_rd_i/_data_i    load result stream, lsu_ready_o = grant
//   reg_wr_en_o/wr_rd_o/wr_data_o  registered register-file write port
//   busy_o                       scoreboard busy mask (bit 0 always 0)
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            issue_rd_we_i,
  input  logic [AW-1:0]   issue_rs1_i,
  input  logic [AW-1:0]   issue_rs2_i,
  output logic            issue_ready_o,
  input  logic            alu_valid_i,
  input  logic [AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            lsu_valid_i,
  input  logic [AW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ready_o,
  output logic            reg_wr_en_o,
  output logic [AW-1:0]   wr_rd_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [NREG-1:0] busy_o
);

  // Pointer records the source granted last; the other one wins the next conflict.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_q, busy_d;
  logic            last_q, last_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            grant_alu_s;
  logic            grant_lsu_s;
  logic            any_grant_s;
  logic [AW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            issue_fire_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Hazard check against registered busy only; no bypass of a same-cycle clear.
  always_comb begin
    issue_ready_o = !busy_q[issue_rs1_i] && !busy_q[issue_rs2_i] &&
                    !(issue_rd_we_i && busy_q[issue_rd_i]);
    issue_fire_s  = issue_valid_i && issue_ready_o;
  end

  // Round-robin arbitration between ALU and LSU result streams.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (alu_valid_i && lsu_valid_i) begin
      if (last_q == SRC_LSU) begin
        grant_alu_s = 1'b1;
      end else begin
        grant_lsu_s = 1'b1;
      end
    end else if (alu_valid_i) begin
      grant_alu_s = 1'b1;
    end else if (lsu_valid_i) begin
      grant_lsu_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
    end
    any_grant_s = grant_alu_s || grant_lsu_s;
    alu_ready_o = grant_alu_s;
    lsu_ready_o = grant_lsu_s;
  end

  // Select the granted source and compute pointer / write-port next state.
  always_comb begin
    if (grant_lsu_s) begin
      sel_rd_s   = lsu_rd_i;
      sel_data_s = lsu_data_i;
      last_d     = SRC_LSU;
    end else if (grant_alu_s) begin
      sel_rd_s   = alu_rd_i;
      sel_data_s = alu_data_i;
      last_d     = SRC_ALU;
    end else begin
      sel_rd_s   = alu_rd_i;
      sel_data_s = alu_data_i;
      last_d     = last_q;
    end
    // A grant to x0 is consumed but never writes the register file.
    wr_en_d   = any_grant_s && (sel_rd_s != {AW{1'b0}});
    wr_rd_d   = any_grant_s ? sel_rd_s   : wr_rd_q;
    wr_data_d = any_grant_s ? sel_data_s : wr_data_q;
  end

  // Scoreboard next state: set on issue, clear on commit, set wins, bit 0 forced low.
  always_comb begin
    clr_mask_s = (any_grant_s && (sel_rd_s != {AW{1'b0}})) ?
                 (ONE_HOT0 << sel_rd_s) : {NREG{1'b0}};
    set_mask_s = (issue_fire_s && issue_rd_we_i && (issue_rd_i != {AW{1'b0}})) ?
                 (ONE_HOT0 << issue_rd_i) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
  end

  // State registers with synchronous reset; ALU gets the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= {NREG{1'b0}};
      last_q    <= SRC_LSU;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= {AW{1'b0}};
      wr_data_q <= {XLEN{1'b0}};
    end else begin
      busy_q    <= busy_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Outputs driven straight from registers.
  always_comb begin
    reg_wr_en_o = wr_en_q;
    wr_rd_o     = wr_rd_q;
    wr_data_o   = wr_data_q;
    busy_o      = busy_q;
  end

endmodule
